sbox_lane_pipe: RTL and testbench
=================================

// Module: sbox_lane_pipe
// PURPOSE
//  Parametrised, pipelined AES byte-substitution engine. Applies the FIPS-197 S-box or the
//  inverse S-box to LANES bytes in parallel, one word per clock. Sits between the round
//  register and ShiftRows in the encrypt/decrypt datapaths, and on the key-expansion SubWord path.
//  Supersedes the single-byte combinational sbox. Adds a valid/ready handshake, backpressure,
//  a per-transaction mode select and a configurable pipeline depth.
// PARAMETERS
//  LANES        16  bytes substituted per transaction (16 = full state, 4 = SubWord); range 1..16
//  PIPE_STAGES  2   register stages input->output, range 1..3; also the latency in cycles
//  INV_EN       1   1: in_inv selects the inverse S-box; 0: forward only, inverse tables not built
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          in_data/in_inv valid this cycle
//  in_ready   out  1          engine accepts a word this cycle
//  in_data    in   8*LANES    byte i = in_data[8*i+7:8*i]
//  in_inv     in   1          1 = inverse S-box, 0 = forward; sampled with in_data
//  out_valid  out  1          out_data/out_inv valid
//  out_ready  in   1          downstream accepts out_data this cycle
//  out_data   out  8*LANES    substituted bytes, same lane order as in_data
//  out_inv    out  1          mode the word was processed with
//  busy       out  1          at least one pipeline stage holds a valid word
// BEHAVIOUR
//  - Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer
//    occurs when out_valid & out_ready.
//  - Pipeline: PIPE_STAGES slots, each holding {valid, inv, data}. Advance enable is
//    adv = !out_valid | out_ready. The advance is global: all slots shift together, or none do.
//  - in_ready = adv. It is purely combinational from out_valid and out_ready, with no dependency
//    on in_valid.
//  - When adv=1: slot0 <= {in_valid, in_inv & INV_EN, in_data}, and slot k <= slot k-1.
//  - When adv=0: every slot holds.
//  - An empty slot advances as a bubble. Bubbles are not collapsed while the pipe is stalled.
//  - Substitution point: the byte lookup is combinational in front of slot0. Stages 1..
//    PIPE_STAGES-1 are retiming registers only.
//  - Outputs: out_valid/out_data/out_inv come directly from the last slot, with no
//    combinational input->output path.
//  - Latency: a word accepted at edge N appears at out_valid after edge N+PIPE_STAGES-1, when
//    not stalled. Throughput is 1 word/cycle when out_ready is held at 1.
//  - Mode: the mode may change on every transaction. Words may alternate between forward and
//    inverse back-to-back, with no flush required.
//  - INV_EN=0: in_inv is ignored and out_inv is always 0.
//  - Stall stability: while out_valid=1 and out_ready=0, out_data and out_inv hold stable
//    (AXI-style). A word is never dropped or duplicated.
//  - Reset: all valid bits clear, data/inv regs = 0.
//    Values after reset: out_valid=0, out_data=0, out_inv=0, busy=0.
//    in_ready=1 during and after reset.
//  - Mid-operation reset: in-flight words are discarded. No output transfer occurs in the
//    cycle after rst.
//  - busy = OR of all slot valid bits.
//  - Table contents: the full 256-entry FIPS-197 forward table, plus the inverse table when
//    INV_EN=1. Each lane has its own lookup instance, with no sharing or time-multiplexing.
//  - Widths: there is no arithmetic. The lookup is a pure 8->8 map per lane.
// TESTING
//  - Reset: assert rst with 3 words in flight. Required: out_valid=0 and busy=0 on the
//    following cycle, and no stale word emerges afterwards.
//  - Forward lookup: LANES=16, in_data bytes {00,01,53,ff,...}, in_inv=0. Required: out bytes
//    {63,7c,ed,16,...}, with latency exactly PIPE_STAGES.
//  - Inverse lookup: in_data bytes {63,7c,ed,16}, in_inv=1. Required: {00,01,53,ff}, out_inv=1.
//    With INV_EN=0, the same stimulus must give {fb,10,55,47} and out_inv=0.
//  - Backpressure: stream 20 words with alternating mode, toggling out_ready pseudo-randomly.
//    Required: all 20 words emerge in order, correct, with no loss or duplication, and
//    out_data is stable during every stall.
//  - Full-rate streaming: out_ready=1 and in_valid=1 for 256 cycles, with in_data[7:0]
//    sweeping 00..ff. Required: one output per cycle, and every byte matches the FIPS-197 table.
//  - Sweep: repeat the suite for PIPE_STAGES=1,2,3 and LANES=4,16.

Source files
------------

// File: rtl/sbox_lane_pipe.sv
// sbox_lane_pipe
//   Pipelined AES byte substitution over LANES bytes per word. Each lane applies either the
//   FIPS-197 forward S-box or, when INV_EN=1 and in_inv=1, the inverse S-box. The lookup sits
//   in front of slot 0, and any further slots are plain retiming registers. Latency is
//   PIPE_STAGES cycles, and throughput is one word per cycle while out_ready stays high.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears all slots
//   in_valid   in_data/in_inv valid this cycle
//   in_ready   engine accepts a word this cycle (= pipeline advance)
//   in_data    8*LANES bits, byte i = in_data[8*i+7:8*i]
//   in_inv     1 = inverse S-box, 0 = forward; sampled with in_data
//   out_valid  out_data/out_inv valid (last slot)
//   out_ready  downstream accepts out_data this cycle
//   out_data   substituted bytes, same lane order as in_data
//   out_inv    mode the word was processed with
//   busy       at least one slot holds a valid word
module sbox_lane_pipe #(
   parameter int unsigned LANES       = 16,
   parameter int unsigned PIPE_STAGES = 2,
   parameter bit          INV_EN      = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic               in_inv,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic               out_inv,
   output logic               busy
);

   localparam int unsigned W    = 8 * LANES;
   localparam int unsigned LAST = PIPE_STAGES - 1;

   localparam logic [7:0] FWD_TBL [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Per-lane lookup in front of slot 0
   logic [W-1:0] sub_data;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [7:0] in_byte;
      logic [7:0] sub_byte;

      assign in_byte = in_data[8*i +: 8];

      if (INV_EN) begin : g_inv
         localparam logic [7:0] INV_TBL [256] = '{
            8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
            8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
            8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
            8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
            8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
            8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
            8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
            8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
            8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
            8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
            8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
            8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
            8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
            8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
            8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
            8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
         };
         assign sub_byte = in_inv ? INV_TBL[in_byte] : FWD_TBL[in_byte];
      end else begin : g_fwd
         assign sub_byte = FWD_TBL[in_byte];
      end

      assign sub_data[8*i +: 8] = sub_byte;
   end

   // Pipeline slots; slot LAST drives the outputs directly
   logic [PIPE_STAGES-1:0] valid_q;
   logic [PIPE_STAGES-1:0] inv_q;
   logic [W-1:0]           data_q [PIPE_STAGES];
   logic                   adv;

   // Global advance: every slot shifts together, so bubbles stay in place while stalled
   assign adv = !valid_q[LAST] | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         inv_q   <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else if (adv) begin
         valid_q[0] <= in_valid;
         inv_q[0]   <= in_inv & INV_EN;
         data_q[0]  <= sub_data;
         for (int k = 1; k < PIPE_STAGES; k++) begin
            valid_q[k] <= valid_q[k-1];
            inv_q[k]   <= inv_q[k-1];
            data_q[k]  <= data_q[k-1];
         end
      end
   end

   assign in_ready  = adv;
   assign out_valid = valid_q[LAST];
   assign out_inv   = inv_q[LAST];
   assign out_data  = data_q[LAST];
   assign busy      = |valid_q;

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Directed bench for sbox_lane_pipe. The main DUT follows the bench parameters. A second DUT,
// with LANES=4, PIPE_STAGES=3, INV_EN=0 and out_ready tied high, shares the input stimulus.
// Reference S-box values come from GF(2^8) inversion plus the affine map.
module tb_sbox_lane_pipe #(
   parameter int unsigned LANES       = 16,
   parameter int unsigned PIPE_STAGES = 2,
   parameter bit          INV_EN      = 1'b1
);

   localparam int unsigned W      = 8 * LANES;
   localparam int unsigned LANES2 = 4;
   localparam int unsigned PIPE2  = 3;
   localparam int unsigned W2     = 8 * LANES2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          in_valid;
   logic          in_inv;
   logic          out_ready;
   logic [127:0]  in_data;
   logic          in_ready, out_valid, out_inv, busy;
   logic [W-1:0]  out_data;
   logic          in_ready2, out_valid2, out_inv2, busy2;
   logic [W2-1:0] out_data2;

   int checks = 0;
   int errors = 0;

   logic [7:0] fwd_m [256];
   logic [7:0] inv_m [256];

   sbox_lane_pipe #(.LANES(LANES), .PIPE_STAGES(PIPE_STAGES), .INV_EN(INV_EN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data[W-1:0]),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_inv   (out_inv),
      .busy      (busy)
   );

   sbox_lane_pipe #(.LANES(LANES2), .PIPE_STAGES(PIPE2), .INV_EN(1'b0)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .in_data   (in_data[W2-1:0]),
      .in_inv    (in_inv),
      .out_valid (out_valid2),
      .out_ready (1'b1),
      .out_data  (out_data2),
      .out_inv   (out_inv2),
      .busy      (busy2)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_model();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b;
         b = '0;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gf_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
         end
         fwd_m[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);
   endtask

   function automatic logic [127:0] exp_word(input logic [127:0] d, input logic inv, input bit en);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) begin
         r[8*k +: 8] = (inv && en) ? inv_m[d[8*k +: 8]] : fwd_m[d[8*k +: 8]];
      end
      return r;
   endfunction

   function automatic logic [127:0] pattern(input int n);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(n * 29 + k * 53 + 7);
      return r;
   endfunction

   function automatic logic [127:0] sweep(input int c);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(c + 17 * k);
      return r;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (out_inv !== 1'b0) begin errors++; $display("FAIL reset_out_inv got %b want 0", out_inv); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid2 !== 1'b0 || busy2 !== 1'b0) begin
         errors++; $display("FAIL reset_dut2 got valid=%b busy=%b want 0 0", out_valid2, busy2);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got ready=%b valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_forward();
      logic [127:0] exp;
      int lat;
      exp = 128'hbae7e060_cd51d053_0904b7ca_16ed7c63;
      out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b0;
      in_data = 128'hc0b0a090_80706050_40302010_ff530100;
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         if (out_valid === 1'b1) begin lat = c; break; end
         @(negedge clk);
      end
      checks++; if (lat != int'(PIPE_STAGES)) begin
         errors++; $display("FAIL fwd_latency got %0d want %0d", lat, PIPE_STAGES);
      end
      checks++; if (out_data !== exp[W-1:0]) begin
         errors++; $display("FAIL fwd_data got %h want %h", out_data, exp[W-1:0]);
      end
      checks++; if (out_inv !== 1'b0) begin errors++; $display("FAIL fwd_inv got %b want 0", out_inv); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_no_dup got %b want 0", out_valid); end
   endtask

   task automatic test_inverse();
      logic [127:0] exp, got;
      logic [31:0]  got2;
      logic         got_inv, got_inv2;
      int lat, lat2;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (PIPE2 + 2) @(negedge clk);
      exp = INV_EN ? {{12{8'h52}}, 32'hff530100} : {{12{8'h63}}, 32'h475510fb};
      got = '0; got2 = '0; got_inv = 1'b0; got_inv2 = 1'b0;
      in_valid = 1'b1; in_inv = 1'b1; in_data = 128'h16ed7c63;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0; lat2 = 0;
      for (int c = 1; c <= 10; c++) begin
         if (lat == 0 && out_valid === 1'b1) begin lat = c; got[W-1:0] = out_data; got_inv = out_inv; end
         if (lat2 == 0 && out_valid2 === 1'b1) begin lat2 = c; got2 = out_data2; got_inv2 = out_inv2; end
         if (lat != 0 && lat2 != 0) break;
         @(negedge clk);
      end
      checks++; if (lat != int'(PIPE_STAGES)) begin
         errors++; $display("FAIL inv_latency got %0d want %0d", lat, PIPE_STAGES);
      end
      checks++; if (got[W-1:0] !== exp[W-1:0]) begin
         errors++; $display("FAIL inv_data got %h want %h", got[W-1:0], exp[W-1:0]);
      end
      checks++; if (got_inv !== INV_EN) begin errors++; $display("FAIL inv_mode got %b want %b", got_inv, INV_EN); end
      checks++; if (lat2 != int'(PIPE2)) begin errors++; $display("FAIL inv_en0_latency got %0d want %0d", lat2, PIPE2); end
      checks++; if (got2 !== 32'h475510fb) begin errors++; $display("FAIL inv_en0_data got %h want 475510fb", got2); end
      checks++; if (got_inv2 !== 1'b0) begin errors++; $display("FAIL inv_en0_mode got %b want 0", got_inv2); end
      repeat (PIPE2 + 2) @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [127:0] exp_q [$];
      logic         exp_inv_q [$];
      logic [127:0] held, e;
      logic         held_inv, ei, stalled;
      int sent, rcvd, extra;
      sent = 0; rcvd = 0; stalled = 1'b0; held = '0; held_inv = 1'b0;
      for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held[W-1:0] || out_inv !== held_inv) begin
               errors++;
               $display("FAIL stall_stable got v=%b d=%h i=%b want v=1 d=%h i=%b",
                        out_valid, out_data, out_inv, held[W-1:0], held_inv);
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
         in_inv    = 1'(sent % 2);
         in_data   = pattern(sent);
         #1;
         stalled = 1'b0;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL bp_extra_word got %h want none", out_data);
            end else begin
               e = exp_q.pop_front(); ei = exp_inv_q.pop_front();
               if (out_data !== e[W-1:0] || out_inv !== ei) begin
                  errors++;
                  $display("FAIL bp_word%0d got %h/%b want %h/%b", rcvd, out_data, out_inv, e[W-1:0], ei);
               end
            end
            rcvd++;
         end else if (out_valid) begin
            held[W-1:0] = out_data; held_inv = out_inv; stalled = 1'b1;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_word(in_data, in_inv, INV_EN));
            exp_inv_q.push_back(in_inv & INV_EN);
            sent++;
         end
      end
      checks++; if (rcvd != 20) begin errors++; $display("FAIL bp_count got %0d want 20", rcvd); end
      in_valid = 1'b0; out_ready = 1'b1; extra = 0;
      repeat (2 * PIPE_STAGES + 2) begin
         @(negedge clk);
         if (out_valid === 1'b1) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL bp_no_dup got %0d want 0", extra); end
   endtask

   task automatic test_stream();
      logic [127:0] q [$];
      logic         qi [$];
      logic [127:0] q2 [$];
      logic [127:0] e;
      logic         ei;
      int n_out, n_out2, gaps, gaps2;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (PIPE2 + 2) @(negedge clk);
      n_out = 0; n_out2 = 0; gaps = 0; gaps2 = 0;
      for (int c = 0; c < 256 + 8; c++) begin
         @(negedge clk);
         if (c < 256) begin
            in_valid = 1'b1; in_inv = 1'(c % 2); in_data = sweep(c);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c >= int'(PIPE_STAGES) && c < 256 + int'(PIPE_STAGES) && out_valid !== 1'b1) gaps++;
         if (c >= int'(PIPE2) && c < 256 + int'(PIPE2) && out_valid2 !== 1'b1) gaps2++;
         if (out_valid === 1'b1) begin
            n_out++;
            if (q.size() != 0) begin
               e = q.pop_front(); ei = qi.pop_front();
               checks++;
               if (out_data !== e[W-1:0] || out_inv !== ei) begin
                  errors++; $display("FAIL stream_word%0d got %h/%b want %h/%b", n_out - 1, out_data, out_inv, e[W-1:0], ei);
               end
            end
         end
         if (out_valid2 === 1'b1) begin
            n_out2++;
            if (q2.size() != 0) begin
               e = q2.pop_front();
               checks++;
               if (out_data2 !== e[W2-1:0] || out_inv2 !== 1'b0) begin
                  errors++; $display("FAIL stream2_word%0d got %h/%b want %h/0", n_out2 - 1, out_data2, out_inv2, e[W2-1:0]);
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(exp_word(in_data, in_inv, INV_EN)); qi.push_back(in_inv & INV_EN);
         end
         if (in_valid && in_ready2) q2.push_back(exp_word(in_data, in_inv, 1'b0));
      end
      checks++; if (n_out != 256) begin errors++; $display("FAIL stream_count got %0d want 256", n_out); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d want 0", gaps); end
      checks++; if (n_out2 != 256) begin errors++; $display("FAIL stream2_count got %0d want 256", n_out2); end
      checks++; if (gaps2 != 0) begin errors++; $display("FAIL stream2_gaps got %0d want 0", gaps2); end
   endtask

   task automatic test_mid_reset();
      int stale;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         in_inv = 1'(n % 2); in_data = pattern(40 + n);
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0 || busy2 !== 1'b0) begin
         errors++; $display("FAIL midrst_busy got %b/%b want 0/0", busy, busy2);
      end
      checks++; if (in_ready !== 1'b1 || out_data !== '0) begin
         errors++; $display("FAIL midrst_regs got ready=%b data=%h want 1 0", in_ready, out_data);
      end
      rst = 1'b0; out_ready = 1'b1; stale = 0;
      repeat (2 * PIPE2 + 2) begin
         @(negedge clk);
         if (out_valid === 1'b1 || out_valid2 === 1'b1) stale++;
      end
      checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale got %0d want 0", stale); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      build_model();
      test_reset();
      test_forward();
      test_inverse();
      test_backpressure();
      test_stream();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
